// File: rtl/drac_pkg.sv
// drac_pkg: shared types for the front end of the core.
//   if_id_stage_t  - fetch-to-decode packet (PC, instruction, exception, prediction)
//   FETCH_QUEUE_DEPTH - number of entries in the fetch/decode decoupling queue
package drac_pkg;

  localparam int FETCH_QUEUE_DEPTH = 4;

  typedef logic [39:0] addr_pc_t;
  typedef logic [31:0] inst_t;

  typedef enum logic [3:0] {
    INSTR_ADDR_MISALIGNED = 4'd0,
    INSTR_ACCESS_FAULT    = 4'd1,
    ILLEGAL_INSTR         = 4'd2,
    BREAKPOINT            = 4'd3,
    INSTR_PAGE_FAULT      = 4'd12,
    NO_EXCEPTION          = 4'd15
  } exception_cause_t;

  typedef struct packed {
    exception_cause_t cause;
    logic [63:0]      origin;
    logic             valid;
  } exception_t;

  typedef struct packed {
    logic     is_branch;
    logic     decision;
    addr_pc_t pred_addr;
  } branch_pred_t;

  typedef struct packed {
    addr_pc_t     pc_inst;
    inst_t        inst;
    logic         valid;
    exception_t   ex;
    branch_pred_t bpred;
  } if_id_stage_t;

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: circular FIFO decoupling fetch from decode.
//   clk_i          - clock, rising edge
//   rst_i          - asynchronous reset, active-high
//   flush_i        - drop all entries and clear the exception lock
//   fetch_i        - packet from fetch; fetch_i.valid requests a push
//   full_o         - no room unless decode pops this cycle (fetch stalls on it)
//   decode_ready_i - decode takes the head this cycle
//   decode_o       - head entry; decode_o.valid = queue not empty
//   count_o        - current occupancy
//
// Handshake: the head transfers to decode on any cycle where decode_o.valid
// and decode_ready_i are both high. Fetch has no ready signal; a valid packet
// that finds the queue full (with no pop), locked, or flushed is dropped, so
// fetch must hold its PC while full_o is high. All outputs decode registered
// state only; neither fetch_i nor decode_ready_i reaches an output
// combinationally.
module fetch_queue
  import drac_pkg::*;
#(
  parameter int DEPTH = FETCH_QUEUE_DEPTH
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  if_id_stage_t               fetch_i,
  output logic                       full_o,
  input  logic                       decode_ready_i,
  output if_id_stage_t               decode_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  if_id_stage_t  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          xcpt_lock;

  logic          not_empty;
  logic          pop;
  logic          push;

  assign not_empty = (count != '0);
  assign pop       = not_empty & decode_ready_i;
  // A pop in the same cycle frees a slot, so a full queue still accepts.
  // Once an excepting packet is queued, everything behind it is wrong path.
  assign push      = fetch_i.valid & ~xcpt_lock & ((count < DEPTH_C) | pop) & ~flush_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      xcpt_lock <= 1'b0;
    end else if (flush_i) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      xcpt_lock <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
      // Popping the excepting entry does not release the lock; only flush does.
      if (push && fetch_i.ex.valid) begin
        xcpt_lock <= 1'b1;
      end
    end
  end

  // Storage is cleared on reset so decode_o reads all-zero afterwards.
  // push already excludes the flush cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      mem[wr_ptr] <= fetch_i;
    end
  end

  always_comb begin
    decode_o       = mem[rd_ptr];
    decode_o.valid = not_empty;
  end

  assign full_o  = (count == DEPTH_C);
  assign count_o = count;

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;
  import drac_pkg::*;

  localparam int DEPTH = FETCH_QUEUE_DEPTH;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int W     = $bits(if_id_stage_t);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk = ~clk;

  logic          flush_i = 1'b0;
  if_id_stage_t  fetch_i = '0;
  logic          full_o;
  logic          decode_ready_i = 1'b0;
  if_id_stage_t  decode_o;
  logic [CW-1:0] count_o;

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .flush_i        (flush_i),
    .fetch_i        (fetch_i),
    .full_o         (full_o),
    .decode_ready_i (decode_ready_i),
    .decode_o       (decode_o),
    .count_o        (count_o)
  );

  // ---------------- scoreboard / reference model ----------------
  logic [W-1:0] exp_q[$];
  logic         m_lock;
  int           total = 0;
  int           bad   = 0;

  function automatic if_id_stage_t mk(input logic [39:0] pc, input logic ex);
    if_id_stage_t p;
    p = '0;
    p.pc_inst         = pc;
    p.inst            = $urandom;
    p.valid           = 1'b1;
    p.ex.valid        = ex;
    p.ex.cause        = ex ? INSTR_PAGE_FAULT : NO_EXCEPTION;
    p.ex.origin       = {24'd0, pc};
    p.bpred.is_branch = 1'($urandom_range(0, 1));
    p.bpred.pred_addr = pc + 40'd64;
    return p;
  endfunction

  // Drive one cycle of inputs, advance the queue model by the spec rules,
  // then step past the rising edge.
  task automatic step(input if_id_stage_t pkt, input logic ready, input logic flush);
    logic m_pop, m_push;
    logic [W-1:0] dropped;
    fetch_i        = pkt;
    decode_ready_i = ready;
    flush_i        = flush;
    m_pop  = (exp_q.size() != 0) && ready;
    m_push = pkt.valid && !m_lock && ((exp_q.size() < DEPTH) || m_pop) && !flush;
    if (flush) begin
      exp_q.delete();
      m_lock = 1'b0;
    end else begin
      if (m_pop) dropped = exp_q.pop_front();
      if (m_push) begin
        exp_q.push_back(pkt);
        if (pkt.ex.valid) m_lock = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    fetch_i        = '0;
    decode_ready_i = 1'b0;
    flush_i        = 1'b0;
  endtask

  task automatic apply_reset();
    fetch_i        = '0;
    decode_ready_i = 1'b0;
    flush_i        = 1'b0;
    rst_i          = 1'b1;
    #3;
    rst_i = 1'b0;
    exp_q.delete();
    m_lock = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (decode_o !== '0) begin
      bad++; $display("FAIL reset_decode: got %h want 0", decode_o);
    end
    total++;
    if (count_o !== '0) begin
      bad++; $display("FAIL reset_count: got %0d want 0", count_o);
    end
    total++;
    if (full_o !== 1'b0) begin
      bad++; $display("FAIL reset_full: got %b want 0", full_o);
    end
    apply_reset();
  endtask

  task automatic test_push_three();
    apply_reset();
    for (int i = 0; i < 3; i++) step(mk(40'h100 + 40'(4 * i), 1'b0), 1'b0, 1'b0);
    total++;
    if (count_o !== CW'(3)) begin
      bad++; $display("FAIL push3_count: got %0d want 3", count_o);
    end
    total++;
    if (full_o !== 1'b0) begin
      bad++; $display("FAIL push3_full: got %b want 0", full_o);
    end
    total++;
    if (decode_o.valid !== 1'b1 || decode_o.pc_inst !== 40'h100) begin
      bad++; $display("FAIL push3_head: got v=%b pc=%h want v=1 pc=100", decode_o.valid, decode_o.pc_inst);
    end
  endtask

  task automatic test_full_wrap();
    logic [39:0] want_pc;
    apply_reset();
    for (int i = 0; i < 4; i++) step(mk(40'h100 + 40'(4 * i), 1'b0), 1'b0, 1'b0);
    total++;
    if (full_o !== 1'b1 || count_o !== CW'(4)) begin
      bad++; $display("FAIL full_set: got full=%b cnt=%0d want full=1 cnt=4", full_o, count_o);
    end
    step(mk(40'h110, 1'b0), 1'b0, 1'b0);
    total++;
    if (count_o !== CW'(4) || decode_o.pc_inst !== 40'h100) begin
      bad++; $display("FAIL full_drop: got cnt=%0d head=%h want cnt=4 head=100", count_o, decode_o.pc_inst);
    end
    step(mk(40'h110, 1'b0), 1'b1, 1'b0);
    total++;
    if (count_o !== CW'(4) || full_o !== 1'b1) begin
      bad++; $display("FAIL full_pushpop: got cnt=%0d full=%b want cnt=4 full=1", count_o, full_o);
    end
    for (int i = 0; i < 4; i++) begin
      want_pc = 40'h104 + 40'(4 * i);
      total++;
      if (decode_o.valid !== 1'b1 || decode_o.pc_inst !== want_pc) begin
        bad++; $display("FAIL wrap_order[%0d]: got v=%b pc=%h want v=1 pc=%h", i, decode_o.valid, decode_o.pc_inst, want_pc);
      end
      step('0, 1'b1, 1'b0);
    end
    total++;
    if (decode_o.valid !== 1'b0 || count_o !== '0) begin
      bad++; $display("FAIL wrap_drain: got v=%b cnt=%0d want v=0 cnt=0", decode_o.valid, count_o);
    end
  endtask

  task automatic test_exception_lock();
    apply_reset();
    step(mk(40'h200, 1'b1), 1'b0, 1'b0);
    step(mk(40'h204, 1'b0), 1'b0, 1'b0);
    total++;
    if (count_o !== CW'(1) || decode_o.pc_inst !== 40'h200 || decode_o.ex.valid !== 1'b1
        || decode_o.ex.cause !== INSTR_PAGE_FAULT) begin
      bad++; $display("FAIL xcpt_lock: got cnt=%0d pc=%h ex=%b cause=%0d want cnt=1 pc=200 ex=1 cause=12",
                      count_o, decode_o.pc_inst, decode_o.ex.valid, decode_o.ex.cause);
    end
    // Popping the trap entry must not release the lock.
    step('0, 1'b1, 1'b0);
    step(mk(40'h208, 1'b0), 1'b0, 1'b0);
    total++;
    if (count_o !== '0) begin
      bad++; $display("FAIL xcpt_lock_after_pop: got cnt=%0d want 0", count_o);
    end
    step('0, 1'b0, 1'b1);
    total++;
    if (count_o !== '0 || decode_o.valid !== 1'b0) begin
      bad++; $display("FAIL flush_clear: got cnt=%0d v=%b want 0 0", count_o, decode_o.valid);
    end
    step(mk(40'h300, 1'b0), 1'b0, 1'b0);
    total++;
    if (count_o !== CW'(1) || decode_o.pc_inst !== 40'h300) begin
      bad++; $display("FAIL flush_reaccept: got cnt=%0d pc=%h want cnt=1 pc=300", count_o, decode_o.pc_inst);
    end
  endtask

  task automatic test_flush_priority();
    apply_reset();
    step(mk(40'h400, 1'b0), 1'b0, 1'b0);
    step(mk(40'h404, 1'b0), 1'b0, 1'b0);
    step(mk(40'h408, 1'b0), 1'b1, 1'b1);
    total++;
    if (count_o !== '0 || decode_o.valid !== 1'b0) begin
      bad++; $display("FAIL flush_priority: got cnt=%0d v=%b want 0 0", count_o, decode_o.valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [39:0] prev_pc;
    apply_reset();
    for (int i = 0; i < 20; i++) begin
      step(mk(40'(4 * i), 1'b0), 1'b1, 1'b0);
      prev_pc = 40'(4 * i);
      total++;
      if (decode_o.valid !== 1'b1 || decode_o.pc_inst !== prev_pc || count_o !== CW'(1)) begin
        bad++; $display("FAIL stream[%0d]: got v=%b pc=%h cnt=%0d want v=1 pc=%h cnt=1",
                        i, decode_o.valid, decode_o.pc_inst, count_o, prev_pc);
      end
    end
    step('0, 1'b1, 1'b0);
    total++;
    if (count_o !== '0) begin
      bad++; $display("FAIL stream_drain: got cnt=%0d want 0", count_o);
    end
  endtask

  task automatic test_async_reset();
    time t0;
    apply_reset();
    for (int i = 0; i < 3; i++) step(mk(40'h500 + 40'(4 * i), 1'b0), 1'b0, 1'b0);
    #2;
    t0 = $time;
    rst_i = 1'b1;
    #1;
    total++;
    if (decode_o.valid !== 1'b0 || count_o !== '0 || full_o !== 1'b0 || ($time - t0) >= 5) begin
      bad++; $display("FAIL async_reset: got v=%b cnt=%0d full=%b want 0 0 0", decode_o.valid, count_o, full_o);
    end
    #2;
    rst_i = 1'b0;
    exp_q.delete();
    m_lock = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    if_id_stage_t p;
    logic [39:0]  pc;
    pc = 40'h1000;
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      total++;
      if (count_o !== CW'(exp_q.size()) || full_o !== (exp_q.size() == DEPTH)
          || decode_o.valid !== (exp_q.size() != 0)) begin
        bad++; $display("FAIL rand_state[%0d]: got cnt=%0d full=%b v=%b want cnt=%0d",
                        i, count_o, full_o, decode_o.valid, exp_q.size());
      end
      if (exp_q.size() != 0) begin
        total++;
        if (decode_o !== exp_q[0]) begin
          bad++; $display("FAIL rand_head[%0d]: got %h want %h", i, decode_o, exp_q[0]);
        end
      end
      p = mk(pc, ($urandom_range(0, 11) == 0));
      p.valid = 1'($urandom_range(0, 3) != 0);
      if (p.valid && !full_o) pc = pc + 40'd4;
      step(p, 1'($urandom_range(0, 2) != 0), ($urandom_range(0, 15) == 0));
    end
  endtask

  initial begin
    m_lock = 1'b0;
    test_reset();
    test_push_three();
    test_full_wrap();
    test_exception_lock();
    test_flush_priority();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
